// File: rtl/dmi_target_bridge_pkg.sv
// Shared debug package: DMI op/response codes, field offsets and the
// bridge FSM state encoding.
package dmi_target_bridge_pkg;

    // Request op codes.
    localparam logic [1:0] DMI_OP_NOP    = 2'd0;
    localparam logic [1:0] DMI_OP_READ   = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE  = 2'd2;

    // Response op codes.
    localparam logic [1:0] DMI_RESP_OK   = 2'd0;
    localparam logic [1:0] DMI_RESP_FAIL = 2'd2;

    // Packed word layout is {addr, data, op}, op at the bottom.
    localparam int unsigned DMI_OP_LSB = 0;

    function automatic int unsigned dmi_data_lsb(input int unsigned op_bits);
        return DMI_OP_LSB + op_bits;
    endfunction

    function automatic int unsigned dmi_addr_lsb(input int unsigned data_bits,
                                                 input int unsigned op_bits);
        return DMI_OP_LSB + op_bits + data_bits;
    endfunction

    function automatic int unsigned dmi_width(input int unsigned addr_bits,
                                              input int unsigned data_bits,
                                              input int unsigned op_bits);
        return addr_bits + data_bits + op_bits;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_RESP      = 2'd2,
        ST_RESP_WAIT = 2'd3
    } dmi_state_e;

endpackage

// File: rtl/dmi_target_bridge_sync2.sv
// Two-flop level synchronizer, asynchronously cleared to 0.
module dmi_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dmi_target_bridge.sv
// DM-side DMI endpoint: takes 4-phase requests from the DTM, runs them on
// the DM register bus and returns {addr,data,op} over a 4-phase response.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a synced request rising edge
// ACCESS     | register access outstanding, timeout counter running
// RESP       | response word loaded; raise dm_resp_o, hold until synced ack
// RESP_WAIT  | dm_resp_o dropped; waiting for synced ack to fall
module dmi_target_bridge
    import dmi_target_bridge_pkg::*;
#(
    parameter int unsigned DMI_ADDR_BITS  = 6,
    parameter int unsigned DMI_DATA_BITS  = 32,
    parameter int unsigned DMI_OP_BITS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               dtm_req_i,
    input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data_i,
    output logic                                               dm_ack_o,
    output logic                                               dm_resp_o,
    output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data_o,
    input  logic                                               dtm_ack_i,
    output logic                                               reg_req_o,
    output logic                                               reg_we_o,
    output logic [DMI_ADDR_BITS-1:0]                           reg_addr_o,
    output logic [DMI_DATA_BITS-1:0]                           reg_wdata_o,
    input  logic                                               reg_done_i,
    input  logic [DMI_DATA_BITS-1:0]                           reg_rdata_i,
    input  logic                                               reg_err_i,
    output logic                                               busy_o
);

    localparam int unsigned DMI_W    = dmi_width(DMI_ADDR_BITS, DMI_DATA_BITS, DMI_OP_BITS);
    localparam int unsigned DATA_LSB = dmi_data_lsb(DMI_OP_BITS);
    localparam int unsigned ADDR_LSB = dmi_addr_lsb(DMI_DATA_BITS, DMI_OP_BITS);
    localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DMI_OP_BITS-1:0] OP_NOP    = DMI_OP_BITS'(DMI_OP_NOP);
    localparam logic [DMI_OP_BITS-1:0] OP_READ   = DMI_OP_BITS'(DMI_OP_READ);
    localparam logic [DMI_OP_BITS-1:0] OP_WRITE  = DMI_OP_BITS'(DMI_OP_WRITE);
    localparam logic [DMI_OP_BITS-1:0] RESP_OK   = DMI_OP_BITS'(DMI_RESP_OK);
    localparam logic [DMI_OP_BITS-1:0] RESP_FAIL = DMI_OP_BITS'(DMI_RESP_FAIL);

    logic req_s;
    logic ack_s;
    logic req_s_q;
    logic req_rise;

    dmi_state_e               state_q, state_d;
    logic                     ack_q, ack_d;
    logic                     resp_q, resp_d;
    logic [DMI_W-1:0]         resp_data_q, resp_data_d;
    logic [DMI_ADDR_BITS-1:0] cap_addr_q, cap_addr_d;
    logic [DMI_DATA_BITS-1:0] cap_data_q, cap_data_d;
    logic [DMI_OP_BITS-1:0]   cap_op_q, cap_op_d;
    logic [DMI_DATA_BITS-1:0] last_rdata_q, last_rdata_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         cnt_inc;

    logic [DMI_ADDR_BITS-1:0] req_addr;
    logic [DMI_DATA_BITS-1:0] req_data;
    logic [DMI_OP_BITS-1:0]   req_op;

    dmi_sync2 u_sync_req (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dtm_req_i),
        .q_o   (req_s)
    );

    dmi_sync2 u_sync_ack (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dtm_ack_i),
        .q_o   (ack_s)
    );

    assign req_addr = dtm_req_data_i[ADDR_LSB +: DMI_ADDR_BITS];
    assign req_data = dtm_req_data_i[DATA_LSB +: DMI_DATA_BITS];
    assign req_op   = dtm_req_data_i[DMI_OP_LSB +: DMI_OP_BITS];
    assign req_rise = req_s & ~req_s_q;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // State, handshake and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_s_q      <= 1'b0;
            ack_q        <= 1'b0;
            resp_q       <= 1'b0;
            resp_data_q  <= '0;
            cap_addr_q   <= '0;
            cap_data_q   <= '0;
            cap_op_q     <= '0;
            last_rdata_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_s_q      <= req_s;
            ack_q        <= ack_d;
            resp_q       <= resp_d;
            resp_data_q  <= resp_data_d;
            cap_addr_q   <= cap_addr_d;
            cap_data_q   <= cap_data_d;
            cap_op_q     <= cap_op_d;
            last_rdata_q <= last_rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state: rx capture, register access with timeout, tx handshake.
    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        resp_d       = resp_q;
        resp_data_d  = resp_data_q;
        cap_addr_d   = cap_addr_q;
        cap_data_d   = cap_data_q;
        cap_op_d     = cap_op_q;
        last_rdata_d = last_rdata_q;
        cnt_d        = cnt_q;

        if (ack_q && !req_s) begin
            ack_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                // Edges seen while ack is still up are dropped, not queued.
                if (req_rise && !ack_q) begin
                    ack_d      = 1'b1;
                    cap_addr_d = req_addr;
                    cap_data_d = req_data;
                    cap_op_d   = req_op;
                    cnt_d      = '0;
                    if (req_op == OP_NOP) begin
                        resp_data_d = {req_addr, last_rdata_q, RESP_OK};
                        state_d     = ST_RESP;
                    end else if (req_op == OP_READ || req_op == OP_WRITE) begin
                        state_d = ST_ACCESS;
                    end else begin
                        resp_data_d = {req_addr, {DMI_DATA_BITS{1'b0}}, RESP_FAIL};
                        state_d     = ST_RESP;
                    end
                end
            end

            ST_ACCESS: begin
                // Done is checked first so it wins over a same-cycle timeout.
                if (reg_done_i) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                    if (reg_err_i) begin
                        resp_data_d = {cap_addr_q, {DMI_DATA_BITS{1'b0}}, RESP_FAIL};
                    end else if (cap_op_q == OP_READ) begin
                        resp_data_d  = {cap_addr_q, reg_rdata_i, RESP_OK};
                        last_rdata_d = reg_rdata_i;
                    end else begin
                        resp_data_d = {cap_addr_q, cap_data_q, RESP_OK};
                    end
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                    resp_data_d = {cap_addr_q, {DMI_DATA_BITS{1'b0}}, RESP_FAIL};
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_RESP: begin
                // Data was loaded on entry, so it is stable before the level rises.
                if (!resp_q) begin
                    resp_d = 1'b1;
                end else if (ack_s) begin
                    resp_d  = 1'b0;
                    state_d = ST_RESP_WAIT;
                end
            end

            ST_RESP_WAIT: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dm_ack_o       = ack_q;
    assign dm_resp_o      = resp_q;
    assign dm_resp_data_o = resp_data_q;
    assign reg_req_o      = (state_q == ST_ACCESS);
    assign reg_we_o       = reg_req_o && (cap_op_q == OP_WRITE);
    assign reg_addr_o     = cap_addr_q;
    assign reg_wdata_o    = cap_data_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmi_target_bridge.sv
// Scoreboard bench for dmi_target_bridge: the main thread plays the DTM
// request side and queues expected responses/accesses; a register-bus
// responder and a DTM response monitor pop and compare independently.
`timescale 1ns/1ps
module tb_dmi_target_bridge;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int OW = 2;
    localparam int W  = AW + DW + OW;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dtm_req_i = 1'b0;
    logic [W-1:0]  dtm_req_data_i = '0;
    logic          dm_ack_o;
    logic          dm_resp_o;
    logic [W-1:0]  dm_resp_data_o;
    logic          dtm_ack_i = 1'b0;
    logic          reg_req_o;
    logic          reg_we_o;
    logic [AW-1:0] reg_addr_o;
    logic [DW-1:0] reg_wdata_o;
    logic          reg_done_i = 1'b0;
    logic [DW-1:0] reg_rdata_i = '0;
    logic          reg_err_i = 1'b0;
    logic          busy_o;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            delay;
        logic [DW-1:0] rdata;
        logic          err;
        int            mode;   // 0 = answer with done, 1 = never answer (timeout), 2 = abort by reset
    } reg_item_t;

    logic [W-1:0] resp_q[$];
    reg_item_t    reg_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay = 1;
    int ack_hold  = 1;
    logic slv_prev = 1'b0;
    logic mon_prev = 1'b0;

    dmi_target_bridge #(
        .DMI_ADDR_BITS  (AW),
        .DMI_DATA_BITS  (DW),
        .DMI_OP_BITS    (OW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dtm_req_i      (dtm_req_i),
        .dtm_req_data_i (dtm_req_data_i),
        .dm_ack_o       (dm_ack_o),
        .dm_resp_o      (dm_resp_o),
        .dm_resp_data_o (dm_resp_data_o),
        .dtm_ack_i      (dtm_ack_i),
        .reg_req_o      (reg_req_o),
        .reg_we_o       (reg_we_o),
        .reg_addr_o     (reg_addr_o),
        .reg_wdata_o    (reg_wdata_o),
        .reg_done_i     (reg_done_i),
        .reg_rdata_i    (reg_rdata_i),
        .reg_err_i      (reg_err_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                          input logic [OW-1:0] o);
        return {a, d, o};
    endfunction

    function automatic reg_item_t mk_item(input logic we, input logic [AW-1:0] a,
                                          input logic [DW-1:0] wd, input int dly,
                                          input logic [DW-1:0] rd, input logic err,
                                          input int mode);
        reg_item_t it;
        it.we = we; it.addr = a; it.wdata = wd; it.delay = dly;
        it.rdata = rd; it.err = err; it.mode = mode;
        return it;
    endfunction

    // Register-bus responder: checks each access against the queued expectation.
    initial begin : reg_slave
        reg_item_t it;
        int hi;
        forever begin
            @(negedge clk);
            if (reg_req_o && !slv_prev) begin
                chk("reg_req_expected", {63'd0, reg_q.size() != 0}, 64'd1);
                if (reg_q.size() != 0) begin
                    it = reg_q.pop_front();
                    chk("reg_we", {63'd0, reg_we_o}, {63'd0, it.we});
                    chk("reg_addr", {58'd0, reg_addr_o}, {58'd0, it.addr});
                    if (it.we) chk("reg_wdata", {32'd0, reg_wdata_o}, {32'd0, it.wdata});
                    if (it.mode == 0) begin
                        repeat (it.delay) @(negedge clk);
                        chk("reg_req_held", {63'd0, reg_req_o}, 64'd1);
                        reg_done_i  = 1'b1;
                        reg_rdata_i = it.rdata;
                        reg_err_i   = it.err;
                        @(negedge clk);
                        reg_done_i  = 1'b0;
                        reg_rdata_i = '0;
                        reg_err_i   = 1'b0;
                        chk("reg_req_drop_after_done", {63'd0, reg_req_o}, 64'd0);
                    end else if (it.mode == 1) begin
                        hi = 1;
                        for (int i = 0; i < 40 && reg_req_o; i++) begin
                            @(negedge clk);
                            if (reg_req_o) hi++;
                        end
                        chk("timeout_access_cycles", 64'(hi), 64'(TO));
                    end else begin
                        hi = 0;
                        while (reg_req_o && hi < 100) begin
                            @(negedge clk);
                            hi++;
                        end
                    end
                end
            end
            slv_prev = reg_req_o;
        end
    end

    // DTM response side: compare each response, check it stays put, then ack it.
    initial begin : resp_mon
        logic [W-1:0] exp_w;
        logic [W-1:0] held;
        int n;
        forever begin
            @(negedge clk);
            if (dm_resp_o && !mon_prev) begin
                chk("resp_expected", {63'd0, resp_q.size() != 0}, 64'd1);
                if (resp_q.size() != 0) begin
                    exp_w = resp_q.pop_front();
                    chk("resp_data", 64'(dm_resp_data_o), 64'(exp_w));
                end
                held = dm_resp_data_o;
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    chk("resp_data_stable", 64'(dm_resp_data_o), 64'(held));
                    chk("resp_held_until_ack", {63'd0, dm_resp_o}, 64'd1);
                end
                dtm_ack_i = 1'b1;
                n = 0;
                while (dm_resp_o && n < 60) begin
                    @(negedge clk);
                    n++;
                end
                chk("resp_drop_after_ack", {63'd0, dm_resp_o}, 64'd0);
                repeat (ack_hold) @(negedge clk);
                dtm_ack_i = 1'b0;
            end
            mon_prev = dm_resp_o;
        end
    end

    task automatic xfer(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [OW-1:0] op, input bit chk_lat);
        int n;
        n = 0;
        @(negedge clk);
        while (dm_ack_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ack_low_before_req", {63'd0, dm_ack_o}, 64'd0);
        dtm_req_data_i = pack(a, d, op);
        dtm_req_i = 1'b1;
        n = 0;
        while (!dm_ack_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ack_rise", {63'd0, dm_ack_o}, 64'd1);
        if (chk_lat) begin
            chk("ack_latency", 64'(n), 64'd3);
            chk("resp_not_yet", {63'd0, dm_resp_o}, 64'd0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ack_held_while_req", {63'd0, dm_ack_o}, 64'd1);
            if (chk_lat && i == 0) chk("nop_resp_latency", {63'd0, dm_resp_o}, 64'd1);
        end
        dtm_req_i = 1'b0;
        n = 0;
        while (dm_ack_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ack_fall", {63'd0, dm_ack_o}, 64'd0);
        chk("ack_fall_latency", 64'(n), 64'd3);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o || dm_ack_o || dtm_ack_i || resp_q.size() != 0 || reg_q.size() != 0)
               && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {63'd0, n < 300}, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        logic quiet;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_dm_ack", {63'd0, dm_ack_o}, 64'd0);
        chk("rst_dm_resp", {63'd0, dm_resp_o}, 64'd0);
        chk("rst_resp_data", 64'(dm_resp_data_o), 64'd0);
        chk("rst_reg_req", {63'd0, reg_req_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // NOP straight after reset returns last_rdata = 0; checks ack/resp latency.
        resp_q.push_back(pack(6'h05, 32'h0, 2'd0));
        xfer(6'h05, 32'hFFFF_FFFF, 2'd0, 1'b1);
        wait_idle();

        // WRITE, done two cycles into the access.
        reg_q.push_back(mk_item(1'b1, 6'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0));
        resp_q.push_back(pack(6'h10, 32'hDEAD_BEEF, 2'd0));
        xfer(6'h10, 32'hDEAD_BEEF, 2'd2, 1'b0);
        wait_idle();

        // READ, then NOP echoes the read data.
        reg_q.push_back(mk_item(1'b0, 6'h11, 32'h0, 1, 32'h1234_5678, 1'b0, 0));
        resp_q.push_back(pack(6'h11, 32'h1234_5678, 2'd0));
        xfer(6'h11, 32'h0, 2'd1, 1'b0);
        wait_idle();
        resp_q.push_back(pack(6'h22, 32'h1234_5678, 2'd0));
        xfer(6'h22, 32'h0, 2'd0, 1'b0);
        wait_idle();

        // READ with error: op=2, data=0, last_rdata untouched.
        reg_q.push_back(mk_item(1'b0, 6'h12, 32'h0, 0, 32'hFFFF_0000, 1'b1, 0));
        resp_q.push_back(pack(6'h12, 32'h0, 2'd2));
        xfer(6'h12, 32'h0, 2'd1, 1'b0);
        wait_idle();
        resp_q.push_back(pack(6'h01, 32'h1234_5678, 2'd0));
        xfer(6'h01, 32'h0, 2'd0, 1'b0);
        wait_idle();

        // WRITE that never completes: timeout after TO access cycles.
        reg_q.push_back(mk_item(1'b1, 6'h13, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, 1));
        resp_q.push_back(pack(6'h13, 32'h0, 2'd2));
        xfer(6'h13, 32'hA5A5_A5A5, 2'd2, 1'b0);
        wait_idle();

        // READ whose done lands in the limit cycle: done wins.
        reg_q.push_back(mk_item(1'b0, 6'h14, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0, 0));
        resp_q.push_back(pack(6'h14, 32'h0BAD_F00D, 2'd0));
        xfer(6'h14, 32'h0, 2'd1, 1'b0);
        wait_idle();

        // Reserved op: no register access; a second request during RESP is dropped.
        ack_delay = 20;
        resp_q.push_back(pack(6'h15, 32'h0, 2'd2));
        xfer(6'h15, 32'h1111_1111, 2'd3, 1'b0);
        chk("still_in_resp", {63'd0, dm_resp_o}, 64'd1);
        dtm_req_data_i = pack(6'h3E, 32'h0, 2'd1);
        dtm_req_i = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (dm_ack_o) quiet = 1'b0;
        end
        chk("no_ack_for_req_in_resp", {63'd0, quiet}, 64'd1);
        dtm_req_i = 1'b0;
        wait_idle();
        ack_delay = 1;

        // DTM keeps ack high: a request during RESP_WAIT must not be captured.
        ack_hold = 15;
        resp_q.push_back(pack(6'h2A, 32'h0BAD_F00D, 2'd0));
        xfer(6'h2A, 32'h0, 2'd0, 1'b0);
        n = 0;
        while (!(dtm_ack_i && !dm_resp_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_resp_wait", {63'd0, n < 50}, 64'd1);
        @(negedge clk);
        dtm_req_data_i = pack(6'h3D, 32'h0, 2'd0);
        dtm_req_i = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (dm_ack_o || !busy_o) quiet = 1'b0;
        end
        chk("no_capture_until_ack_low", {63'd0, quiet}, 64'd1);
        dtm_req_i = 1'b0;
        wait_idle();
        ack_hold = 1;
        resp_q.push_back(pack(6'h2B, 32'h0BAD_F00D, 2'd0));
        xfer(6'h2B, 32'h0, 2'd0, 1'b0);
        wait_idle();

        // Reset in the middle of an access clears all outputs without a clock.
        reg_q.push_back(mk_item(1'b1, 6'h30, 32'h5555_AAAA, 0, 32'h0, 1'b0, 2));
        @(negedge clk);
        dtm_req_data_i = pack(6'h30, 32'h5555_AAAA, 2'd2);
        dtm_req_i = 1'b1;
        n = 0;
        while (!reg_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_access", {63'd0, reg_req_o}, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_dm_ack", {63'd0, dm_ack_o}, 64'd0);
        chk("arst_dm_resp", {63'd0, dm_resp_o}, 64'd0);
        chk("arst_resp_data", 64'(dm_resp_data_o), 64'd0);
        chk("arst_reg_req", {63'd0, reg_req_o}, 64'd0);
        chk("arst_reg_we", {63'd0, reg_we_o}, 64'd0);
        chk("arst_reg_addr", {58'd0, reg_addr_o}, 64'd0);
        chk("arst_reg_wdata", {32'd0, reg_wdata_o}, 64'd0);
        chk("arst_busy", {63'd0, busy_o}, 64'd0);
        dtm_req_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_idle();

        // Fresh READ after reset, then NOP to confirm last_rdata.
        reg_q.push_back(mk_item(1'b0, 6'h3F, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 0));
        resp_q.push_back(pack(6'h3F, 32'hCAFE_F00D, 2'd0));
        xfer(6'h3F, 32'h0, 2'd1, 1'b0);
        wait_idle();
        resp_q.push_back(pack(6'h20, 32'hCAFE_F00D, 2'd0));
        xfer(6'h20, 32'h0, 2'd0, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
